// File: rtl/audio_pkg.sv
// Shared audio/I2S widths and status-counter helpers.
`timescale 1ns/1ps
package audio_pkg;
  localparam int AUDIO_W        = 16;
  localparam int I2S_FRAME_BITS = 32;
  localparam int I2S_SLOT_BITS  = 16;
  localparam int BIT_CNT_W      = $clog2(I2S_FRAME_BITS);

  localparam logic [15:0] STAT_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != STAT_CNT_MAX)) ? v + 16'd1 : v;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; occupancy tracked by an extra pointer MSB.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             push_ok, pop_ok;

  // Fullness is judged on the pre-pop state, so a push in a full pop cycle drops.
  always_comb begin
    push_ok  = push && !full_q;
    pop_ok   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/i2s_tx.sv
// Mono-to-stereo I2S transmitter with BCLK/LRCK generation and a sample FIFO.
// Optional saturating status counters: define I2S_TX_STATUS_CNT_EN.
`timescale 1ns/1ps
module i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AUDIO_W-1:0] audio_in,
  input  logic               datain_valid,
  output logic               i2s_bclk,
  output logic               i2s_lrck,
  output logic               i2s_sdata,
  output logic               fifo_full,
  output logic               overflow,
  output logic               underrun
`ifdef I2S_TX_STATUS_CNT_EN
  ,
  output logic [15:0]        ovf_cnt,
  output logic [15:0]        udr_cnt
`endif
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]     DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(I2S_FRAME_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LRCK_FIRST = BIT_CNT_W'(I2S_SLOT_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LRCK_LAST  = BIT_CNT_W'(I2S_FRAME_BITS - 2);

  logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [I2S_FRAME_BITS-1:0] frame_sr_q, frame_sr_d;
  logic bclk_q, bclk_d, sdata_q, sdata_d, lrck_q, lrck_d;
  logic ovf_q, ovf_d, udr_q, udr_d;
  logic fall, frame_start, fifo_pop, fifo_empty, fifo_full_w;
  logic [AUDIO_W-1:0] fifo_rdata;

  sync_fifo #(.WIDTH(AUDIO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (datain_valid),
    .wdata (audio_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full_w),
    .empty (fifo_empty)
  );

  always_comb begin
    div_cnt_d  = div_cnt_q + 1'b1;
    bclk_d     = bclk_q;
    bit_cnt_d  = bit_cnt_q;
    frame_sr_d = frame_sr_q;
    sdata_d    = sdata_q;
    lrck_d     = lrck_q;
    fall       = 1'b0;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
      fall      = bclk_q;
    end
    frame_start = fall && (bit_cnt_q == BIT_LAST);
    fifo_pop    = frame_start && !fifo_empty;
    // Serial outputs change only on BCLK falls, giving a full half-period of setup.
    if (fall) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (frame_start) begin
        frame_sr_d = fifo_empty ? '0 : {fifo_rdata, fifo_rdata};
      end
      sdata_d = frame_sr_d[BIT_LAST - bit_cnt_d];
      lrck_d  = (bit_cnt_d >= LRCK_FIRST) && (bit_cnt_d <= LRCK_LAST);
    end
    ovf_d = datain_valid && fifo_full_w;
    udr_d = frame_start && fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= BIT_LAST;
      frame_sr_q <= '0;
      sdata_q    <= 1'b0;
      lrck_q     <= 1'b0;
      ovf_q      <= 1'b0;
      udr_q      <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_sr_q <= frame_sr_d;
      sdata_q    <= sdata_d;
      lrck_q     <= lrck_d;
      ovf_q      <= ovf_d;
      udr_q      <= udr_d;
    end
  end

  assign i2s_bclk  = bclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = sdata_q;
  assign fifo_full = fifo_full_w;
  assign overflow  = ovf_q;
  assign underrun  = udr_q;

`ifdef I2S_TX_STATUS_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d, udr_cnt_q, udr_cnt_d;

  // Counters step together with the pulse they count.
  always_comb begin
    ovf_cnt_d = sat_inc(ovf_cnt_q, ovf_d);
    udr_cnt_d = sat_inc(udr_cnt_q, udr_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
      udr_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      udr_cnt_q <= udr_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign udr_cnt = udr_cnt_q;
`endif
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: cycle-level reference model built from frame arithmetic and a sample queue.
`timescale 1ns/1ps
module tb_i2s_tx;
  localparam int CD        = 4;
  localparam int DEPTH     = 8;
  localparam int FRAME_CYC = 64 * CD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] audio_in = '0;
  logic        datain_valid = 1'b0;
  logic        i2s_bclk, i2s_lrck, i2s_sdata, fifo_full, overflow, underrun;
`ifdef I2S_TX_STATUS_CNT_EN
  logic [15:0] ovf_cnt, udr_cnt;
  int          m_ovf, m_udr;
`endif

  always #5 clk = ~clk;

  i2s_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .audio_in     (audio_in),
    .datain_valid (datain_valid),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .underrun     (underrun)
`ifdef I2S_TX_STATUS_CNT_EN
    ,
    .ovf_cnt      (ovf_cnt),
    .udr_cnt      (udr_cnt)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc;
  logic [15:0] q[$];
  logic [15:0] cur_s;
  logic        e_ovf, e_udr, prev_bclk, prev_lrck;
  int          last_rise, last_lrise, frames_done = 0, ovf_seen = 0, udr_seen = 0;
  logic [31:0] cap, last_frame, f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // BCLK falls every 2*CD clk after release; frame k starts on fall 32k+1.
  function automatic int bit_of(int n);
    return ((n / (2 * CD)) + 31) % 32;
  endfunction

  function automatic bit is_boundary(int n);
    return (n > 0) && (n % (2 * CD) == 0) && ((n / (2 * CD)) % 32 == 1);
  endfunction

  task automatic reset_model();
    cyc = 0; q.delete(); cur_s = '0;
    prev_bclk = 1'b0; prev_lrck = 1'b0;
    last_rise = -1; last_lrise = -1; cap = '0; last_frame = '0;
`ifdef I2S_TX_STATUS_CNT_EN
    m_ovf = 0; m_udr = 0;
`endif
  endtask

  task automatic tick();
    int   pre, bc;
    logic x_bclk, x_lrck, x_sdata, x_full;
    @(posedge clk);
    pre = q.size();
    cyc++;
    e_ovf = 1'b0; e_udr = 1'b0;
    if (is_boundary(cyc)) begin
      if (pre > 0) cur_s = q.pop_front();
      else begin cur_s = '0; e_udr = 1'b1; end
    end
    if (datain_valid) begin
      if (pre >= DEPTH) e_ovf = 1'b1;
      else q.push_back(audio_in);
    end
    #1;
    bc      = bit_of(cyc);
    x_bclk  = ((cyc / CD) % 2) == 1;
    x_lrck  = (bc >= 15) && (bc <= 30);
    x_sdata = cur_s[15 - (bc % 16)];
    x_full  = (q.size() == DEPTH);
    chk("cycle{bclk,lrck,sdata,full,ovf,udr}",
        32'({i2s_bclk, i2s_lrck, i2s_sdata, fifo_full, overflow, underrun}),
        32'({x_bclk, x_lrck, x_sdata, x_full, e_ovf, e_udr}));
`ifdef I2S_TX_STATUS_CNT_EN
    if (e_ovf && m_ovf < 65535) m_ovf++;
    if (e_udr && m_udr < 65535) m_udr++;
    chk("ovf_cnt", 32'(ovf_cnt), m_ovf);
    chk("udr_cnt", 32'(udr_cnt), m_udr);
`endif
    if (!prev_bclk && i2s_bclk) begin
      if (last_rise >= 0) chk("bclk_period", cyc - last_rise, 2 * CD);
      last_rise = cyc;
      cap = {cap[30:0], i2s_sdata};
      if (bc == 31) begin last_frame = cap; frames_done++; end
    end
    if (!prev_lrck && i2s_lrck) begin
      if (last_lrise >= 0) chk("lrck_period", cyc - last_lrise, FRAME_CYC);
      last_lrise = cyc;
    end
    ovf_seen += int'(overflow);
    udr_seen += int'(underrun);
    prev_bclk = i2s_bclk;
    prev_lrck = i2s_lrck;
  endtask

  task automatic push(input logic [15:0] v);
    audio_in = v; datain_valid = 1'b1;
    tick();
    datain_valid = 1'b0;
  endtask

  task automatic wait_boundary();
    for (int k = 0; k < 2 * FRAME_CYC; k++) begin
      tick();
      if (is_boundary(cyc)) break;
    end
  endtask

  task automatic next_frame(output logic [31:0] fr);
    int start = frames_done;
    for (int k = 0; k < 2 * FRAME_CYC && frames_done == start; k++) tick();
    chk("frame_timeout", 32'(frames_done != start), 1);
    fr = last_frame;
  endtask

  initial begin
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({i2s_bclk, i2s_lrck, i2s_sdata, fifo_full, overflow, underrun}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle two frames: one underrun per frame, all-zero data.
    udr_seen = 0;
    repeat (2 * FRAME_CYC) tick();
    chk("idle_underruns", udr_seen, 2);

    // Single sample appears in both slots of the following frame.
    wait_boundary();
    push(16'hA5C3);
    next_frame(f);
    next_frame(f);
    chk("frame_a5c3", f, 32'hA5C3_A5C3);

    wait_boundary();
    push(16'h8000);
    push(16'h7FFF);
    next_frame(f);
    next_frame(f);
    chk("frame_8000", f, 32'h8000_8000);
    next_frame(f);
    chk("frame_7fff", f, 32'h7FFF_7FFF);

    // Back-to-back burst of 10 into an empty FIFO.
    wait_boundary();
    ovf_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      push(16'(i));
      if (i == 7) chk("full_after_7", 32'(fifo_full), 0);
      if (i == 8) chk("full_after_8", 32'(fifo_full), 1);
    end
    tick();
    chk("burst_overflows", ovf_seen, 2);
    next_frame(f);
    for (int i = 1; i <= 8; i++) begin
      next_frame(f);
      chk("burst_frame", f, {16'(i), 16'(i)});
    end
    udr_seen = 0;
    next_frame(f);
    chk("post_burst_frame", f, 0);
    chk("post_burst_underrun", udr_seen, 1);

    // Push on the exact clk of a frame-wrap pop with 7 entries held.
    wait_boundary();
    for (int k = 0; k < 7; k++) push(16'($urandom));
    for (int k = 0; k < 2 * FRAME_CYC && !is_boundary(cyc + 1); k++) tick();
    push(16'($urandom));
    chk("wrap_push_no_ovf", 32'(overflow), 0);
    chk("wrap_push_not_full", 32'(fifo_full), 0);
    push(16'($urandom));
    chk("wrap_push_then_full", 32'(fifo_full), 1);

    // Random sparse traffic against the model.
    for (int k = 0; k < 16 * FRAME_CYC; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        audio_in = 16'($urandom); datain_valid = 1'b1;
      end
      tick();
      datain_valid = 1'b0;
    end

    // Asynchronous reset in the middle of bit 20.
    for (int k = 0; k < 2 * FRAME_CYC && bit_of(cyc) != 20; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({i2s_bclk, i2s_lrck, i2s_sdata, fifo_full, overflow, underrun}), 0);
`ifdef I2S_TX_STATUS_CNT_EN
    chk("async_reset_ovf_cnt", 32'(ovf_cnt), 0);
    chk("async_reset_udr_cnt", 32'(udr_cnt), 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    push(16'h1234);
    next_frame(f);
    next_frame(f);
    chk("post_reset_frame", f, 32'h1234_1234);
    udr_seen = 0;
    repeat (FRAME_CYC) tick();
    chk("post_reset_underrun", udr_seen, 1);
    for (int i = 0; i < 10; i++) push(16'($urandom));
    repeat (FRAME_CYC) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
